// File: rtl/proc_ctrl_pkg.sv
// Shared control encodings for TinyRV1 controllers and datapaths.
// Contents: datapath control-field encodings, the multicycle FSM state type
// and the instruction-class type produced by proc_ctrl_decode.
package proc_ctrl_pkg;

  // pc_sel
  localparam logic [1:0] PcPlus4 = 2'd0;
  localparam logic [1:0] PcBr    = 2'd1;
  localparam logic [1:0] PcJr    = 2'd2;

  // imm_type
  localparam logic [1:0] ImmI = 2'd0;
  localparam logic [1:0] ImmS = 2'd1;
  localparam logic [1:0] ImmJ = 2'd2;
  localparam logic [1:0] ImmB = 2'd3;

  // op2_sel
  localparam logic Op2Rf  = 1'b0;
  localparam logic Op2Imm = 1'b1;

  // alu_func
  localparam logic AluAdd = 1'b0;
  localparam logic AluEq  = 1'b1;

  // wb_sel
  localparam logic [1:0] WbPc4 = 2'd0;
  localparam logic [1:0] WbMul = 2'd1;
  localparam logic [1:0] WbAlu = 2'd2;
  localparam logic [1:0] WbMem = 2'd3;

  // dmem_type
  localparam logic DmemRd = 1'b0;
  localparam logic DmemWr = 1'b1;

  typedef enum logic [2:0] {
    StF,
    StX,
    StM,
    StK,
    StH
  } ctrl_state_e;

  typedef enum logic [3:0] {
    IcIllegal,
    IcAdd,
    IcAddi,
    IcMul,
    IcLw,
    IcSw,
    IcJal,
    IcJr,
    IcBne
  } inst_class_e;

endpackage

// File: rtl/proc_ctrl_decode.sv
// Combinational TinyRV1 decoder: instruction word -> instruction class plus
// the static datapath control fields for that class. The branch outcome
// (alu_eq) is not known here, so pc_sel for BNE is the taken value.
// Ports:
//   inst_i     instruction register contents
//   class_o    inst_class_e encoding (IcIllegal when nothing matches)
//   pc_sel_o, imm_type_o, op2_sel_o, alu_func_o, wb_sel_o, rf_wen_o
//              static control fields
module proc_ctrl_decode
  import proc_ctrl_pkg::*;
(
  input  logic [31:0] inst_i,
  output logic [3:0]  class_o,
  output logic [1:0]  pc_sel_o,
  output logic [1:0]  imm_type_o,
  output logic        op2_sel_o,
  output logic        alu_func_o,
  output logic [1:0]  wb_sel_o,
  output logic        rf_wen_o
);

  inst_class_e cls;

  always_comb begin
    cls        = IcIllegal;
    pc_sel_o   = PcPlus4;
    imm_type_o = ImmI;
    op2_sel_o  = Op2Rf;
    alu_func_o = AluAdd;
    wb_sel_o   = WbPc4;
    rf_wen_o   = 1'b0;
    casez (inst_i)
      32'b0000000_?????_?????_000_?????_0110011: begin
        cls      = IcAdd;
        wb_sel_o = WbAlu;
        rf_wen_o = 1'b1;
      end
      32'b0000001_?????_?????_000_?????_0110011: begin
        cls      = IcMul;
        wb_sel_o = WbMul;
        rf_wen_o = 1'b1;
      end
      32'b???????_?????_?????_000_?????_0010011: begin
        cls       = IcAddi;
        op2_sel_o = Op2Imm;
        wb_sel_o  = WbAlu;
        rf_wen_o  = 1'b1;
      end
      32'b???????_?????_?????_010_?????_0000011: begin
        cls       = IcLw;
        op2_sel_o = Op2Imm;
        wb_sel_o  = WbMem;
        rf_wen_o  = 1'b1;
      end
      32'b???????_?????_?????_010_?????_0100011: begin
        cls        = IcSw;
        imm_type_o = ImmS;
        op2_sel_o  = Op2Imm;
      end
      32'b???????_?????_?????_???_?????_1101111: begin
        cls        = IcJal;
        pc_sel_o   = PcBr;
        imm_type_o = ImmJ;
        rf_wen_o   = 1'b1;
      end
      // jr is jalr x0, rs1, 0
      32'b000000000000_?????_000_00000_1100111: begin
        cls      = IcJr;
        pc_sel_o = PcJr;
      end
      32'b???????_?????_?????_001_?????_1100011: begin
        cls        = IcBne;
        pc_sel_o   = PcBr;
        imm_type_o = ImmB;
        alu_func_o = AluEq;
      end
      default: ;
    endcase
  end

  assign class_o = cls;

endmodule

// File: rtl/proc_mcycle_ctrl.sv
// Multicycle TinyRV1 control unit. Sequences each instruction through
// fetch (F), execute (X), memory (M), iterative multiply (K) or halt (H).
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   imem_val_o / imem_wait_i  fetch request / fetch stall
//   dmem_val_o / dmem_wait_i  data request / data stall, dmem_type_o 0=rd 1=wr
//   trace_val_o, trace_wen_o  retire strobe and its register write flag
//   pc_sel_o .. rf_wen_o      datapath control bus
//   pc_en_o, ir_en_o          PC update, IR latch
//   mul_en_o, mul_clr_o       multiplier step, multiplier load/clear
//   halted_o                  sticky illegal-instruction flag
//   inst_i, alu_eq_i          IR contents, ALU equality result
module proc_mcycle_ctrl
  import proc_ctrl_pkg::*;
#(
  parameter int unsigned MUL_ITERS       = 32,
  parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_val_o,
  input  logic        imem_wait_i,
  output logic        dmem_val_o,
  input  logic        dmem_wait_i,
  output logic        dmem_type_o,
  output logic        trace_val_o,
  output logic        trace_wen_o,
  output logic [1:0]  pc_sel_o,
  output logic [1:0]  imm_type_o,
  output logic        op2_sel_o,
  output logic        alu_func_o,
  output logic [1:0]  wb_sel_o,
  output logic        rf_wen_o,
  output logic        pc_en_o,
  output logic        ir_en_o,
  output logic        mul_en_o,
  output logic        mul_clr_o,
  output logic        halted_o,
  input  logic [31:0] inst_i,
  input  logic        alu_eq_i
);

  localparam int unsigned CntW = (MUL_ITERS > 1) ? $clog2(MUL_ITERS) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(MUL_ITERS - 1);

  ctrl_state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic halted_q, halted_d;

  logic [3:0] dec_class;
  logic [1:0] dec_pc_sel, dec_imm_type, dec_wb_sel;
  logic       dec_op2_sel, dec_alu_func, dec_rf_wen;
  inst_class_e cls;

  proc_ctrl_decode u_decode (
    .inst_i     (inst_i),
    .class_o    (dec_class),
    .pc_sel_o   (dec_pc_sel),
    .imm_type_o (dec_imm_type),
    .op2_sel_o  (dec_op2_sel),
    .alu_func_o (dec_alu_func),
    .wb_sel_o   (dec_wb_sel),
    .rf_wen_o   (dec_rf_wen)
  );

  assign cls = inst_class_e'(dec_class);

  logic       imem_val, dmem_val, dmem_type, retire;
  logic [1:0] pc_sel, imm_type, wb_sel;
  logic       op2_sel, alu_func, rf_wen, pc_en, ir_en, mul_en, mul_clr;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StF;
      cnt_q    <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    halted_d  = halted_q;
    imem_val  = 1'b0;
    dmem_val  = 1'b0;
    dmem_type = DmemRd;
    retire    = 1'b0;
    pc_sel    = PcPlus4;
    imm_type  = ImmI;
    op2_sel   = Op2Rf;
    alu_func  = AluAdd;
    wb_sel    = WbPc4;
    rf_wen    = 1'b0;
    pc_en     = 1'b0;
    ir_en     = 1'b0;
    mul_en    = 1'b0;
    mul_clr   = 1'b0;
    unique case (state_q)
      StF: begin
        imem_val = 1'b1;
        if (!imem_wait_i) begin
          ir_en   = 1'b1;
          state_d = StX;
        end
      end
      StX: begin
        case (cls)
          IcAdd, IcAddi, IcJal, IcJr, IcBne: begin
            pc_sel   = dec_pc_sel;
            imm_type = dec_imm_type;
            op2_sel  = dec_op2_sel;
            alu_func = dec_alu_func;
            wb_sel   = dec_wb_sel;
            rf_wen   = dec_rf_wen;
            if (cls == IcBne && alu_eq_i) pc_sel = PcPlus4;
            pc_en    = 1'b1;
            retire   = 1'b1;
            state_d  = StF;
          end
          IcLw, IcSw: state_d = StM;
          IcMul: begin
            mul_clr = 1'b1;
            cnt_d   = CntLoad;
            state_d = StK;
          end
          default: begin
            if (HALT_ON_ILLEGAL) begin
              halted_d = 1'b1;
              state_d  = StH;
            end else begin
              pc_en   = 1'b1;
              retire  = 1'b1;
              state_d = StF;
            end
          end
        endcase
      end
      StM: begin
        // Fields are held constant for the whole access; only the
        // completion strobes depend on dmem_wait.
        dmem_val  = 1'b1;
        dmem_type = (cls == IcSw) ? DmemWr : DmemRd;
        imm_type  = dec_imm_type;
        op2_sel   = dec_op2_sel;
        alu_func  = dec_alu_func;
        wb_sel    = dec_wb_sel;
        if (!dmem_wait_i) begin
          rf_wen  = dec_rf_wen;
          pc_en   = 1'b1;
          retire  = 1'b1;
          state_d = StF;
        end
      end
      StK: begin
        mul_en = 1'b1;
        if (cnt_q == '0) begin
          wb_sel  = WbMul;
          rf_wen  = 1'b1;
          pc_en   = 1'b1;
          retire  = 1'b1;
          state_d = StF;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StH: ;
      default: state_d = StF;
    endcase
  end

  // Every output is forced low while reset is held, including the F-state
  // fetch request and the sticky halt flag.
  logic live;
  assign live = ~rst_i;

  assign imem_val_o  = imem_val & live;
  assign dmem_val_o  = dmem_val & live;
  assign dmem_type_o = dmem_type & live;
  assign trace_val_o = retire & live;
  assign trace_wen_o = rf_wen & live;
  assign pc_sel_o    = pc_sel & {2{live}};
  assign imm_type_o  = imm_type & {2{live}};
  assign op2_sel_o   = op2_sel & live;
  assign alu_func_o  = alu_func & live;
  assign wb_sel_o    = wb_sel & {2{live}};
  assign rf_wen_o    = rf_wen & live;
  assign pc_en_o     = pc_en & live;
  assign ir_en_o     = ir_en & live;
  assign mul_en_o    = mul_en & live;
  assign mul_clr_o   = mul_clr & live;
  assign halted_o    = halted_q & live;

endmodule

// File: tb/tb_proc_mcycle_ctrl.sv
// Directed bench for proc_mcycle_ctrl. Two instances share stimulus:
// dut_a halts on illegal instructions, dut_b retires them as no-ops.
// Both use MUL_ITERS=4. Each cycle the full output bus is compared
// against a hand-written expected value.
module tb_proc_mcycle_ctrl;

  typedef struct packed {
    logic       imem_val;
    logic       dmem_val;
    logic       dmem_type;
    logic       trace_val;
    logic       trace_wen;
    logic [1:0] pc_sel;
    logic [1:0] imm_type;
    logic       op2_sel;
    logic       alu_func;
    logic [1:0] wb_sel;
    logic       rf_wen;
    logic       pc_en;
    logic       ir_en;
    logic       mul_en;
    logic       mul_clr;
    logic       halted;
  } ctl_t;

  localparam logic [31:0] InstAddi = 32'h0050_0093;
  localparam logic [31:0] InstAdd  = 32'h0020_81B3;
  localparam logic [31:0] InstLw   = 32'h0000_A103;
  localparam logic [31:0] InstSw   = 32'h0020_A023;
  localparam logic [31:0] InstMul  = 32'h0220_81B3;
  localparam logic [31:0] InstBne  = 32'h0020_9063;
  localparam logic [31:0] InstJal  = 32'h0000_00EF;
  localparam logic [31:0] InstJr   = 32'h0000_8067;

  logic        clk = 1'b0;
  logic        rst, imem_wait, dmem_wait, alu_eq;
  logic [31:0] inst;

  logic       imem_val_a, dmem_val_a, dmem_type_a, trace_val_a, trace_wen_a;
  logic [1:0] pc_sel_a, imm_type_a, wb_sel_a;
  logic       op2_sel_a, alu_func_a, rf_wen_a, pc_en_a, ir_en_a, mul_en_a, mul_clr_a;
  logic       halted_a;
  logic       imem_val_b, dmem_val_b, dmem_type_b, trace_val_b, trace_wen_b;
  logic [1:0] pc_sel_b, imm_type_b, wb_sel_b;
  logic       op2_sel_b, alu_func_b, rf_wen_b, pc_en_b, ir_en_b, mul_en_b, mul_clr_b;
  logic       halted_b;

  ctl_t ctl_a, ctl_b;
  assign ctl_a = {imem_val_a, dmem_val_a, dmem_type_a, trace_val_a, trace_wen_a, pc_sel_a,
                  imm_type_a, op2_sel_a, alu_func_a, wb_sel_a, rf_wen_a, pc_en_a, ir_en_a,
                  mul_en_a, mul_clr_a, halted_a};
  assign ctl_b = {imem_val_b, dmem_val_b, dmem_type_b, trace_val_b, trace_wen_b, pc_sel_b,
                  imm_type_b, op2_sel_b, alu_func_b, wb_sel_b, rf_wen_b, pc_en_b, ir_en_b,
                  mul_en_b, mul_clr_b, halted_b};

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  proc_mcycle_ctrl #(.MUL_ITERS(4), .HALT_ON_ILLEGAL(1'b1)) dut_a (
    .clk_i(clk), .rst_i(rst),
    .imem_val_o(imem_val_a), .imem_wait_i(imem_wait),
    .dmem_val_o(dmem_val_a), .dmem_wait_i(dmem_wait), .dmem_type_o(dmem_type_a),
    .trace_val_o(trace_val_a), .trace_wen_o(trace_wen_a),
    .pc_sel_o(pc_sel_a), .imm_type_o(imm_type_a), .op2_sel_o(op2_sel_a),
    .alu_func_o(alu_func_a), .wb_sel_o(wb_sel_a), .rf_wen_o(rf_wen_a),
    .pc_en_o(pc_en_a), .ir_en_o(ir_en_a), .mul_en_o(mul_en_a), .mul_clr_o(mul_clr_a),
    .halted_o(halted_a), .inst_i(inst), .alu_eq_i(alu_eq)
  );

  proc_mcycle_ctrl #(.MUL_ITERS(4), .HALT_ON_ILLEGAL(1'b0)) dut_b (
    .clk_i(clk), .rst_i(rst),
    .imem_val_o(imem_val_b), .imem_wait_i(imem_wait),
    .dmem_val_o(dmem_val_b), .dmem_wait_i(dmem_wait), .dmem_type_o(dmem_type_b),
    .trace_val_o(trace_val_b), .trace_wen_o(trace_wen_b),
    .pc_sel_o(pc_sel_b), .imm_type_o(imm_type_b), .op2_sel_o(op2_sel_b),
    .alu_func_o(alu_func_b), .wb_sel_o(wb_sel_b), .rf_wen_o(rf_wen_b),
    .pc_en_o(pc_en_b), .ir_en_o(ir_en_b), .mul_en_o(mul_en_b), .mul_clr_o(mul_clr_b),
    .halted_o(halted_b), .inst_i(inst), .alu_eq_i(alu_eq)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Expected bus for an F cycle whose fetch completes.
  function automatic ctl_t fetch_done();
    ctl_t e;
    e = '0;
    e.imem_val = 1'b1;
    e.ir_en    = 1'b1;
    return e;
  endfunction

  task automatic do_reset();
    rst = 1'b1; imem_wait = 1'b0; dmem_wait = 1'b0; alu_eq = 1'b0; inst = 32'h0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    ctl_t e;
    rst = 1'b1; imem_wait = 1'b0; dmem_wait = 1'b0; alu_eq = 1'b0; inst = InstAddi;
    cyc();
    cyc();
    e = '0;
    total++;
    if (ctl_a !== e) begin bad++; $display("FAIL reset_a got=%h exp=%h", ctl_a, e); end
    total++;
    if (ctl_b !== e) begin bad++; $display("FAIL reset_b got=%h exp=%h", ctl_b, e); end
    rst = 1'b0;
    #1;
    e = fetch_done();
    total++;
    if (ctl_a !== e) begin bad++; $display("FAIL reset_release got=%h exp=%h", ctl_a, e); end
  endtask

  task automatic test_addi();
    ctl_t e;
    do_reset();
    inst = InstAddi;
    for (int c = 0; c < 3; c++) begin
      #1;
      e = '0;
      if (c == 1) begin
        e.rf_wen = 1'b1; e.pc_en = 1'b1; e.trace_val = 1'b1; e.trace_wen = 1'b1;
        e.wb_sel = 2'd2; e.op2_sel = 1'b1;
      end else begin
        e = fetch_done();
      end
      total++;
      if (ctl_a !== e) begin bad++; $display("FAIL addi c=%0d got=%h exp=%h", c, ctl_a, e); end
      cyc();
    end
  endtask

  task automatic test_lw_waits();
    ctl_t e;
    do_reset();
    inst = InstLw;
    for (int c = 0; c < 9; c++) begin
      imem_wait = (c < 2);
      dmem_wait = (c >= 4 && c <= 6);
      #1;
      e = '0;
      if (c <= 1) e.imem_val = 1'b1;
      else if (c == 2 || c == 8) e = fetch_done();
      else if (c >= 4 && c <= 7) begin
        e.dmem_val = 1'b1; e.op2_sel = 1'b1; e.wb_sel = 2'd3;
        if (c == 7) begin
          e.rf_wen = 1'b1; e.pc_en = 1'b1; e.trace_val = 1'b1; e.trace_wen = 1'b1;
        end
      end
      total++;
      if (ctl_a !== e) begin bad++; $display("FAIL lw c=%0d got=%h exp=%h", c, ctl_a, e); end
      cyc();
    end
    imem_wait = 1'b0;
    dmem_wait = 1'b0;
  endtask

  task automatic test_sw();
    ctl_t e;
    do_reset();
    inst = InstSw;
    for (int c = 0; c < 4; c++) begin
      #1;
      e = '0;
      if (c == 0 || c == 3) e = fetch_done();
      else if (c == 2) begin
        e.dmem_val = 1'b1; e.dmem_type = 1'b1; e.imm_type = 2'd1; e.op2_sel = 1'b1;
        e.pc_en = 1'b1; e.trace_val = 1'b1;
      end
      total++;
      if (ctl_a !== e) begin bad++; $display("FAIL sw c=%0d got=%h exp=%h", c, ctl_a, e); end
      cyc();
    end
  endtask

  task automatic test_mul();
    ctl_t e;
    do_reset();
    inst = InstMul;
    for (int c = 0; c < 7; c++) begin
      #1;
      e = '0;
      if (c == 0 || c == 6) e = fetch_done();
      else if (c == 1) e.mul_clr = 1'b1;
      else begin
        e.mul_en = 1'b1;
        if (c == 5) begin
          e.wb_sel = 2'd1; e.rf_wen = 1'b1; e.pc_en = 1'b1;
          e.trace_val = 1'b1; e.trace_wen = 1'b1;
        end
      end
      total++;
      if (ctl_a !== e) begin bad++; $display("FAIL mul c=%0d got=%h exp=%h", c, ctl_a, e); end
      cyc();
    end
  endtask

  task automatic test_bne();
    ctl_t e;
    do_reset();
    inst = InstBne;
    for (int k = 0; k < 2; k++) begin
      alu_eq = (k == 1);
      for (int c = 0; c < 2; c++) begin
        #1;
        e = '0;
        if (c == 0) e = fetch_done();
        else begin
          e.pc_sel = (k == 1) ? 2'd0 : 2'd1;
          e.imm_type = 2'd3; e.alu_func = 1'b1; e.pc_en = 1'b1; e.trace_val = 1'b1;
        end
        total++;
        if (ctl_a !== e) begin
          bad++; $display("FAIL bne eq=%0d c=%0d got=%h exp=%h", k, c, ctl_a, e);
        end
        cyc();
      end
    end
    alu_eq = 1'b0;
  endtask

  task automatic test_back_to_back();
    ctl_t e;
    logic [31:0] prog [3];
    prog[0] = InstAdd; prog[1] = InstJal; prog[2] = InstJr;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      inst = prog[k];
      for (int c = 0; c < 2; c++) begin
        #1;
        e = '0;
        if (c == 0) e = fetch_done();
        else begin
          e.pc_en = 1'b1; e.trace_val = 1'b1;
          if (k == 0) begin
            e.wb_sel = 2'd2; e.rf_wen = 1'b1; e.trace_wen = 1'b1;
          end else if (k == 1) begin
            e.pc_sel = 2'd1; e.imm_type = 2'd2; e.rf_wen = 1'b1; e.trace_wen = 1'b1;
          end else begin
            e.pc_sel = 2'd2;
          end
        end
        total++;
        if (ctl_a !== e) begin
          bad++; $display("FAIL b2b k=%0d c=%0d got=%h exp=%h", k, c, ctl_a, e);
        end
        cyc();
      end
    end
  endtask

  task automatic test_reset_mid();
    ctl_t e;
    // Abort during the second multiply step.
    do_reset();
    inst = InstMul;
    for (int c = 0; c < 6; c++) begin
      rst = (c == 3 || c == 4);
      #1;
      e = '0;
      if (c == 0 || c == 5) e = fetch_done();
      else if (c == 1) e.mul_clr = 1'b1;
      else if (c == 2) e.mul_en = 1'b1;
      total++;
      if (ctl_a !== e) begin bad++; $display("FAIL rst_k c=%0d got=%h exp=%h", c, ctl_a, e); end
      cyc();
    end
    // Abort during a stalled load.
    do_reset();
    inst = InstLw;
    for (int c = 0; c < 5; c++) begin
      rst = (c == 3);
      dmem_wait = (c >= 2 && c <= 3);
      #1;
      e = '0;
      if (c == 0 || c == 4) e = fetch_done();
      else if (c == 2) begin e.dmem_val = 1'b1; e.op2_sel = 1'b1; e.wb_sel = 2'd3; end
      total++;
      if (ctl_a !== e) begin bad++; $display("FAIL rst_m c=%0d got=%h exp=%h", c, ctl_a, e); end
      cyc();
    end
    rst = 1'b0;
    dmem_wait = 1'b0;
  endtask

  task automatic test_illegal();
    ctl_t e, eb;
    do_reset();
    inst = 32'h0000_0000;
    for (int c = 0; c < 24; c++) begin
      rst = (c == 22);
      #1;
      e = '0;
      if (c == 0 || c == 23) e = fetch_done();
      else if (c >= 2 && c <= 21) e.halted = 1'b1;
      total++;
      if (ctl_a !== e) begin bad++; $display("FAIL halt c=%0d got=%h exp=%h", c, ctl_a, e); end
      if (c <= 2) begin
        eb = '0;
        if (c == 1) begin eb.pc_en = 1'b1; eb.trace_val = 1'b1; end
        else eb = fetch_done();
        total++;
        if (ctl_b !== eb) begin
          bad++; $display("FAIL nop_illegal c=%0d got=%h exp=%h", c, ctl_b, eb);
        end
      end
      cyc();
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_lw_waits();
    test_sw();
    test_mul();
    test_bne();
    test_back_to_back();
    test_reset_mid();
    test_illegal();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
